// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, two-cycle
// flush sequencing, downstream hold and a saturating bubble counter.
module id_ex_stage #(
  parameter logic [3:0] ALU_NOP = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  // ID operand / instruction fields
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  // decode control
  input  logic        ASel_i,
  input  logic        BSel_i,
  input  logic        BrUn_i,
  input  logic        MemR_i,
  input  logic        MemW_i,
  input  logic        RegWEn_i,
  input  logic [1:0]  WBSel_i,
  input  logic [3:0]  ALUSel_i,
  // hazards
  input  logic        flush_i,
  input  logic        hold_i,
  // EX-side registered fields
  output logic [31:0] pc_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic        ASel_o,
  output logic        BSel_o,
  output logic        BrUn_o,
  output logic        MemR_o,
  output logic        MemW_o,
  output logic        RegWEn_o,
  output logic [1:0]  WBSel_o,
  output logic [3:0]  ALUSel_o,
  output logic        valid_o,
  output logic        stall_o,
  output logic [15:0] bubble_cnt_o
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        a_sel;
    logic        b_sel;
    logic        br_un;
    logic        mem_r;
    logic        mem_w;
    logic        reg_wen;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_sel;
    logic        valid;
  } ex_t;

  // A bubble writes nothing, reads no memory and selects ALU result for WB.
  localparam ex_t BUBBLE = '{
    pc: '0, rs1_data: '0, rs2_data: '0, imm: '0,
    rs1: '0, rs2: '0, rd: '0, funct3: '0,
    a_sel: 1'b0, b_sel: 1'b0, br_un: 1'b0,
    mem_r: 1'b0, mem_w: 1'b0, reg_wen: 1'b0,
    wb_sel: 2'b01, alu_sel: ALU_NOP, valid: 1'b0
  };

  state_t      state;
  ex_t         ex;
  ex_t         id_fields;
  logic [15:0] bubble_cnt;
  logic        rd_match;

  // Collect the ID-side inputs into one bundle for capture.
  always_comb begin
    id_fields = '{
      pc: pc_i, rs1_data: rs1_data_i, rs2_data: rs2_data_i, imm: imm_i,
      rs1: rs1_i, rs2: rs2_i, rd: rd_i, funct3: funct3_i,
      a_sel: ASel_i, b_sel: BSel_i, br_un: BrUn_i,
      mem_r: MemR_i, mem_w: MemW_i, reg_wen: RegWEn_i,
      wb_sel: WBSel_i, alu_sel: ALUSel_i, valid: 1'b1
    };
  end

  // Load-use hazard: a valid load in EX writing a register ID is about to read.
  // x0 never carries a hazard; flush and hold both suppress the stall.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd_match = 1'b0;
    stall_o  = 1'b0;
    rd_match = (ex.rd == rs1_i) || (ex.rd == rs2_i);
    stall_o  = ex.valid && ex.mem_r && ex.reg_wen && (ex.rd != 5'd0) &&
               rd_match && (state == RUN) && !flush_i && !hold_i;
  end

  // Pipeline register, flush FSM and bubble counter, in priority order.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is
    // synchronous, so it sits inside the clocked branch like any other condition.
    if (!rst_n) begin
      ex         <= BUBBLE;
      state      <= RUN;
      bubble_cnt <= '0;
    end else if (flush_i) begin
      ex         <= BUBBLE;
      state      <= FLUSH;
      bubble_cnt <= (bubble_cnt == 16'hFFFF) ? bubble_cnt : bubble_cnt + 16'd1;
    end else if (hold_i) begin
      ex         <= ex;
      state      <= state;
      bubble_cnt <= bubble_cnt;
    end else if (state == FLUSH) begin
      ex         <= BUBBLE;
      state      <= RUN;
      bubble_cnt <= (bubble_cnt == 16'hFFFF) ? bubble_cnt : bubble_cnt + 16'd1;
    end else if (stall_o) begin
      ex         <= BUBBLE;
      bubble_cnt <= (bubble_cnt == 16'hFFFF) ? bubble_cnt : bubble_cnt + 16'd1;
    end else begin
      ex <= id_fields;
    end
  end

  assign pc_o         = ex.pc;
  assign rs1_data_o   = ex.rs1_data;
  assign rs2_data_o   = ex.rs2_data;
  assign imm_o        = ex.imm;
  assign rs1_o        = ex.rs1;
  assign rs2_o        = ex.rs2;
  assign rd_o         = ex.rd;
  assign funct3_o     = ex.funct3;
  assign ASel_o       = ex.a_sel;
  assign BSel_o       = ex.b_sel;
  assign BrUn_o       = ex.br_un;
  assign MemR_o       = ex.mem_r;
  assign MemW_o       = ex.mem_w;
  assign RegWEn_o     = ex.reg_wen;
  assign WBSel_o      = ex.wb_sel;
  assign ALUSel_o     = ex.alu_sel;
  assign valid_o      = ex.valid;
  assign bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: normal capture, load-use stall,
// flush sequencing, hold vs flush, x0 boundary, reset mid-flush, saturation.
module tb_id_ex_stage;

  localparam logic [3:0] ALU_NOP = 4'hF;
  localparam logic [3:0] ALU_ADD = 4'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic [2:0]  funct3_i;
  logic        ASel_i, BSel_i, BrUn_i, MemR_i, MemW_i, RegWEn_i;
  logic [1:0]  WBSel_i;
  logic [3:0]  ALUSel_i;
  logic        flush_i, hold_i;
  logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;
  logic        ASel_o, BSel_o, BrUn_o, MemR_o, MemW_o, RegWEn_o;
  logic [1:0]  WBSel_o;
  logic [3:0]  ALUSel_o;
  logic        valid_o, stall_o;
  logic [15:0] bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.ALU_NOP(ALU_NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .funct3_i(funct3_i),
    .ASel_i(ASel_i), .BSel_i(BSel_i), .BrUn_i(BrUn_i), .MemR_i(MemR_i),
    .MemW_i(MemW_i), .RegWEn_i(RegWEn_i), .WBSel_i(WBSel_i), .ALUSel_i(ALUSel_i),
    .flush_i(flush_i), .hold_i(hold_i),
    .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(funct3_o),
    .ASel_o(ASel_o), .BSel_o(BSel_o), .BrUn_o(BrUn_o), .MemR_o(MemR_o),
    .MemW_o(MemW_o), .RegWEn_o(RegWEn_o), .WBSel_o(WBSel_o), .ALUSel_o(ALUSel_o),
    .valid_o(valid_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mem_r, input logic reg_wen,
                       input logic [1:0] wb_sel, input logic [3:0] alu_sel);
    pc_i       = pc;
    rs1_i      = rs1;
    rs2_i      = rs2;
    rd_i       = rd;
    MemR_i     = mem_r;
    RegWEn_i   = reg_wen;
    WBSel_i    = wb_sel;
    ALUSel_i   = alu_sel;
    rs1_data_i = pc + 32'h1000;
    rs2_data_i = pc + 32'h2000;
    imm_i      = pc + 32'h3000;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    funct3_i = 3'd2; ASel_i = 1'b1; BSel_i = 1'b1; BrUn_i = 1'b0; MemW_i = 1'b0;
    drive(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, ALU_ADD);

    // Reset loads a bubble and clears the counter
    tick(); tick();
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_cnt", {16'b0, bubble_cnt_o}, 32'd0);
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_wbsel", {30'b0, WBSel_o}, 32'd1);
    check("rst_alusel", {28'b0, ALUSel_o}, {28'b0, ALU_NOP});
    check("rst_asel", {31'b0, ASel_o}, 32'd0);

    // Normal ADD capture
    rst_n = 1'b1;
    drive(32'h10, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 2'b01, ALU_ADD);
    #1 check("post_rst_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check("add_rd", {27'b0, rd_o}, 32'd5);
    check("add_pc", pc_o, 32'h10);
    check("add_valid", {31'b0, valid_o}, 32'd1);
    check("add_cnt", {16'b0, bubble_cnt_o}, 32'd0);
    check("add_rs1data", rs1_data_o, 32'h1010);
    check("add_funct3", {29'b0, funct3_o}, 32'd2);

    // Load-use: LW x7 in EX, consumer reads x7 via rs2
    drive(32'h14, 5'd2, 5'd3, 5'd7, 1'b1, 1'b1, 2'b00, ALU_ADD);
    tick();
    check("lw_memr", {31'b0, MemR_o}, 32'd1);
    drive(32'h18, 5'd1, 5'd7, 5'd8, 1'b0, 1'b1, 2'b01, ALU_ADD);
    #1 check("lu_stall", {31'b0, stall_o}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'b0, valid_o}, 32'd0);
    check("lu_bubble_memr", {31'b0, MemR_o}, 32'd0);
    check("lu_bubble_wbsel", {30'b0, WBSel_o}, 32'd1);
    check("lu_cnt", {16'b0, bubble_cnt_o}, 32'd1);
    check("lu_stall_after", {31'b0, stall_o}, 32'd0);
    tick();
    check("lu_capture_valid", {31'b0, valid_o}, 32'd1);
    check("lu_capture_pc", pc_o, 32'h18);
    check("lu_capture_rd", {27'b0, rd_o}, 32'd8);

    // Single-cycle flush: two bubbles, then capture
    drive(32'h1C, 5'd1, 5'd2, 5'd9, 1'b0, 1'b1, 2'b01, ALU_ADD);
    flush_i = 1'b1;
    #1 check("flush_stall", {31'b0, stall_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    check("fl1_valid", {31'b0, valid_o}, 32'd0);
    check("fl1_cnt", {16'b0, bubble_cnt_o}, 32'd2);
    tick();
    check("fl2_valid", {31'b0, valid_o}, 32'd0);
    check("fl2_cnt", {16'b0, bubble_cnt_o}, 32'd3);
    tick();
    check("fl3_valid", {31'b0, valid_o}, 32'd1);
    check("fl3_pc", pc_o, 32'h1C);
    check("fl3_cnt", {16'b0, bubble_cnt_o}, 32'd3);

    // Flush again during FLUSH: three bubbles total
    flush_i = 1'b1;
    tick();
    check("rf1_cnt", {16'b0, bubble_cnt_o}, 32'd4);
    tick();
    flush_i = 1'b0;
    check("rf2_valid", {31'b0, valid_o}, 32'd0);
    check("rf2_cnt", {16'b0, bubble_cnt_o}, 32'd5);
    tick();
    check("rf3_valid", {31'b0, valid_o}, 32'd0);
    check("rf3_cnt", {16'b0, bubble_cnt_o}, 32'd6);
    tick();
    check("rf4_valid", {31'b0, valid_o}, 32'd1);
    check("rf4_cnt", {16'b0, bubble_cnt_o}, 32'd6);

    // Hold with a pending load-use hazard: frozen, no stall
    drive(32'h20, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 2'b00, ALU_ADD);
    tick();
    drive(32'h24, 5'd3, 5'd2, 5'd4, 1'b0, 1'b1, 2'b01, ALU_ADD);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", {31'b0, stall_o}, 32'd0);
      tick();
      check("hold_pc", pc_o, 32'h20);
      check("hold_rd", {27'b0, rd_o}, 32'd3);
      check("hold_valid", {31'b0, valid_o}, 32'd1);
      check("hold_cnt", {16'b0, bubble_cnt_o}, 32'd6);
    end
    hold_i = 1'b0;
    #1 check("unhold_stall", {31'b0, stall_o}, 32'd1);

    // Hold with flush: flush wins
    hold_i = 1'b1; flush_i = 1'b1;
    #1 check("hf_stall", {31'b0, stall_o}, 32'd0);
    tick();
    hold_i = 1'b0; flush_i = 1'b0;
    check("hf_valid", {31'b0, valid_o}, 32'd0);
    check("hf_cnt", {16'b0, bubble_cnt_o}, 32'd7);
    tick();
    check("hf2_valid", {31'b0, valid_o}, 32'd0);
    check("hf2_cnt", {16'b0, bubble_cnt_o}, 32'd8);
    tick();
    check("hf3_valid", {31'b0, valid_o}, 32'd1);
    check("hf3_pc", pc_o, 32'h24);

    // x0 destination is never a hazard
    drive(32'h30, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 2'b00, ALU_ADD);
    tick();
    drive(32'h34, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 2'b01, ALU_ADD);
    #1 check("x0_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check("x0_valid", {31'b0, valid_o}, 32'd1);
    check("x0_pc", pc_o, 32'h34);
    check("x0_cnt", {16'b0, bubble_cnt_o}, 32'd8);

    // Reset in the middle of a flush sequence
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("mf_cnt", {16'b0, bubble_cnt_o}, 32'd9);
    rst_n = 1'b0;
    tick();
    check("mf_rst_valid", {31'b0, valid_o}, 32'd0);
    check("mf_rst_cnt", {16'b0, bubble_cnt_o}, 32'd0);
    rst_n = 1'b1;
    drive(32'h40, 5'd1, 5'd2, 5'd10, 1'b0, 1'b1, 2'b01, ALU_ADD);
    #1 check("mf_post_stall", {31'b0, stall_o}, 32'd0);
    tick();
    check("mf_post_valid", {31'b0, valid_o}, 32'd1);
    check("mf_post_pc", pc_o, 32'h40);
    check("mf_post_cnt", {16'b0, bubble_cnt_o}, 32'd0);

    // Saturation: 65535 consecutive flush bubbles, then more
    flush_i = 1'b1;
    repeat (65535) @(posedge clk);
    #1 check("sat_reach", {16'b0, bubble_cnt_o}, 32'h0000FFFF);
    tick();
    check("sat_hold", {16'b0, bubble_cnt_o}, 32'h0000FFFF);
    flush_i = 1'b0;
    tick();
    check("sat_flushstate", {16'b0, bubble_cnt_o}, 32'h0000FFFF);
    tick();
    check("sat_capture_valid", {31'b0, valid_o}, 32'd1);
    check("sat_final_cnt", {16'b0, bubble_cnt_o}, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  reset, synchronous, active-low.
REQ-002 SHALL have ID-side inputs: pc_i 32, rs1_data_i 32, rs2_data_i 32, imm_i 32, rs1_i 5, rs2_i 5, rd_i 5, funct3_i 3, ID operand/instruction fields.
REQ-003 SHALL have control inputs from decode: ASel_i 1, BSel_i 1, BrUn_i 1, MemR_i 1, MemW_i 1, RegWEn_i 1, WBSel_i 2, ALUSel_i 4.
REQ-004 SHALL have hazard inputs: flush_i 1, branch/jump taken in EX (kill younger); hold_i 1, downstream memory busy (freeze EX).
REQ-005 SHALL have registered outputs: one *_o per REQ-002/003 input, same width, plus valid_o 1 (EX holds a real instruction).
REQ-006 SHALL have outputs: stall_o 1, combinational, freeze PC and IF/ID; bubble_cnt_o 16, bubbles inserted since reset.

Function
REQ-007 SHALL register all REQ-002/003 inputs to *_o on each rising clk edge when in RUN, hold_i=0, flush_i=0, stall_o=0 (latency 1 cycle); valid_o=1.
REQ-008 Bubble definition: MemR_o=MemW_o=RegWEn_o=0, ALUSel_o=ALUnop, WBSel_o=2'b01, all data/index outputs 0, valid_o=0.
REQ-009 Load-use detect (combinational): stall_o=1 iff valid_o & MemR_o & RegWEn_o & rd_o!=0 & (rd_o==rs1_i | rd_o==rs2_i) & state==RUN & flush_i=0 & hold_i=0.
REQ-010 On stall_o=1, EX SHALL load a bubble; ID inputs are held upstream and captured next cycle.
REQ-011 FSM states: RUN, FLUSH; reset state RUN.
REQ-012 RUN->FLUSH on flush_i=1: EX loads bubble that cycle; FLUSH loads a second bubble then ->RUN (two younger instructions killed).
REQ-013 flush_i=1 while in FLUSH SHALL restart the sequence (bubble, stay FLUSH one more cycle).
REQ-014 Priority, highest first: rst_n=0 > flush_i > hold_i > FLUSH-state bubble > stall_o > normal capture.
REQ-015 hold_i=1 (no flush) SHALL keep every output and state unchanged; stall_o=0 while hold_i=1.
REQ-016 bubble_cnt_o SHALL increment by 1 per bubble loaded (REQ-010/012/013), saturate at 16'hFFFF, never wrap.
REQ-017 stall_o SHALL be 0 in FLUSH state and whenever flush_i=1.
REQ-018 rd_o==0 SHALL never trigger stall_o (x0 is never a hazard).

Reset
REQ-019 rst_n=0 sampled at a rising edge SHALL load a bubble (REQ-008), state RUN, bubble_cnt_o=0; reset bubble not counted.
REQ-020 Reset mid-FLUSH or mid-hold SHALL abandon the sequence; first cycle after rst_n=1 is normal RUN capture.
REQ-021 stall_o SHALL be 0 during and in the cycle after reset (valid_o=0).

Verification
REQ-022 Normal: ADD (RegWEn_i=1, ALUSel_i=ALUadd, rd_i=5, pc_i=0x10) one cycle -> next cycle rd_o=5, pc_o=0x10, valid_o=1, bubble_cnt_o=0.
REQ-023 Load-use: LW rd=7 in EX, ID rs2_i=7 -> stall_o=1 same cycle; next cycle bubble, valid_o=0, bubble_cnt_o=1; following cycle ID instruction captured, valid_o=1.
REQ-024 Flush: flush_i=1 one cycle in RUN -> two consecutive bubble cycles, bubble_cnt_o +2, RUN on third cycle; flush_i again during FLUSH -> total three bubbles.
REQ-025 Hold vs flush: hold_i=1 for 3 cycles with LW rd=3 in EX and rs1_i=3 -> outputs frozen, stall_o=0; hold_i=1 with flush_i=1 -> bubble loaded (flush wins).
REQ-026 Boundaries: LW rd=0, rs1_i=0 -> stall_o=0; force bubble_cnt_o to 0xFFFF via 65535 flushes-equivalent (or preload in sim) then one more bubble -> stays 0xFFFF.
REQ-027 Reset mid-FLUSH: rst_n=0 in FLUSH cycle -> bubble, bubble_cnt_o=0; after release new instruction captured immediately, valid_o=1.
